// File: rtl/snowflake_pkg.sv
// Shared definitions for the snowflake 7-segment display controller:
// register offsets, CTRL field layout and the packed CTRL register type.
package snowflake_pkg;

  localparam logic [7:0] SSD_CTRL   = 8'h00;
  localparam logic [7:0] SSD_STATUS = 8'h04;
  localparam logic [7:0] SSD_DIGIT0 = 8'h08;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_BRIGHT_LSB = 4;
  localparam int CTRL_BRIGHT_MSB = 7;

  typedef struct packed {
    logic [3:0] bright;
    logic       en;
  } ssd_ctrl_t;

  // Places the stored CTRL fields back at their bus bit positions; all other bits read 0.
  function automatic logic [31:0] ctrl_to_word(input ssd_ctrl_t c);
    logic [31:0] w;
    w = '0;
    w[CTRL_EN_BIT] = c.en;
    w[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB] = c.bright;
    return w;
  endfunction

endpackage

// File: rtl/snowflake_ssd_scan.sv
// Scan timing for the display: prescaler -> 16-step PWM counter -> digit index.
// Counters run while en=1 and clear to zero on the first edge with en=0.
module snowflake_ssd_scan #(
  parameter int NUM_DIGITS = 2,
  parameter int CLK_DIV    = 1000
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  output logic [2:0] digit_idx,
  output logic [3:0] pwm_cnt,
  output logic       tick
);

  logic [15:0] r_presc;
  logic [3:0]  r_pwm;
  logic [2:0]  r_idx;

  assign tick      = en && (r_presc == 16'(CLK_DIV - 1));
  assign digit_idx = r_idx;
  assign pwm_cnt   = r_pwm;

  // NOTE: state registers use non-blocking assignments so every counter samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_presc <= '0;
      r_pwm   <= '0;
      r_idx   <= '0;
    end else if (!en) begin
      r_presc <= '0;
      r_pwm   <= '0;
      r_idx   <= '0;
    end else if (tick) begin
      r_presc <= '0;
      r_pwm   <= r_pwm + 4'd1;
      if (r_pwm == 4'hF) begin
        r_idx <= (r_idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : r_idx + 3'd1;
      end
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

endmodule

// File: rtl/snowflake_ssd_ctrl.sv
// Multiplexed 7-segment display controller with a snowflake-bus register slave:
// register file, read mux, scan engine instance and registered polarity stage.
module snowflake_ssd_ctrl
  import snowflake_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int CLK_DIV        = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rstz,
  input  logic [7:0]            sys_addr,
  input  logic [31:0]           sys_wr_data,
  input  logic                  sys_en,
  input  logic                  sys_wr_en,
  output logic [31:0]           sys_rd_data,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] sel
);

  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};

  logic [7:0]  w_addr;
  logic        w_wr;
  logic        w_rd;
  logic [31:0] w_rd_next;
  logic [2:0]  w_digit_idx;
  logic [3:0]  w_pwm_cnt;
  logic        w_tick;
  logic        w_active;
  logic [6:0]  w_pattern;
  logic [6:0]  w_seg_next;
  logic [NUM_DIGITS-1:0] w_sel_next;
  logic        w_unused;

  ssd_ctrl_t   r_ctrl;
  logic [6:0]  r_digit [NUM_DIGITS];
  logic [31:0] r_rd_data;
  logic        r_en_d;
  logic [6:0]  r_seg;
  logic [NUM_DIGITS-1:0] r_sel;

  assign w_addr   = {sys_addr[7:2], 2'b00};
  assign w_wr     = sys_en && sys_wr_en;
  assign w_rd     = sys_en && !sys_wr_en;
  assign w_unused = ^{sys_wr_data[31:8], sys_addr[1:0], w_tick};

  // NOTE: the digit registers are reset along with CTRL because a display that
  // powers up showing stale patterns is visible to the user; the file is tiny.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_ctrl <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= '0;
    end else if (w_wr) begin
      if (w_addr == SSD_CTRL) begin
        r_ctrl.en     <= sys_wr_data[CTRL_EN_BIT];
        r_ctrl.bright <= sys_wr_data[CTRL_BRIGHT_MSB:CTRL_BRIGHT_LSB];
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_addr == SSD_DIGIT0 + 8'(4 * i)) r_digit[i] <= sys_wr_data[6:0];
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    w_rd_next = '0;
    if (w_addr == SSD_CTRL) begin
      w_rd_next = ctrl_to_word(r_ctrl);
    end else if (w_addr == SSD_STATUS) begin
      w_rd_next = {24'd0, w_pwm_cnt, 1'b0, w_digit_idx};
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_addr == SSD_DIGIT0 + 8'(4 * i)) w_rd_next = {25'd0, r_digit[i]};
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_rd_data <= '0;
    end else if (w_rd) begin
      r_rd_data <= w_rd_next;
    end
  end

  snowflake_ssd_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .CLK_DIV    (CLK_DIV)
  ) u_scan (
    .clk       (clk),
    .rstz      (rstz),
    .en        (r_ctrl.en),
    .digit_idx (w_digit_idx),
    .pwm_cnt   (w_pwm_cnt),
    .tick      (w_tick)
  );

  // Outputs stay live for the one cycle in which the counters clear after a
  // disable, so the pins go dark two edges after the CTRL write.
  assign w_active = r_ctrl.en || r_en_d;

  always_comb begin
    w_pattern  = '0;
    w_sel_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_digit_idx == 3'(i)) w_pattern = r_digit[i];
      w_sel_next[i] = w_active && (w_digit_idx == 3'(i));
    end
    w_seg_next = (w_active && (w_pwm_cnt < r_ctrl.bright)) ? w_pattern : 7'd0;
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      r_en_d <= 1'b0;
      r_seg  <= SEG_OFF;
      r_sel  <= SEL_OFF;
    end else begin
      r_en_d <= r_ctrl.en;
      r_seg  <= w_seg_next ^ SEG_OFF;
      r_sel  <= w_sel_next ^ SEL_OFF;
    end
  end

  assign sys_rd_data = r_rd_data;
  assign seg         = r_seg;
  assign sel         = r_sel;

endmodule

// File: doc/snowflake_ssd_ctrl.md
Name: snowflake_ssd_ctrl

Overview:
Parametrised multi-digit 7-segment display controller with a memory-mapped register slave on the snowflake system bus (sys_* side). It time-multiplexes NUM_DIGITS digits over one shared segment bus. It adds a programmable scan rate, 16-level PWM brightness, configurable output polarity and a readable scan status. It replaces the fixed 2-digit GPIO-style display registers and driver in the snowflake top level.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits; legal range 1..8.
CLK_DIV, 1000, clk cycles per scan tick; legal range 2..65535.
SEG_ACTIVE_LOW, 0, 1 = seg outputs are inverted at the pin (lit segment = 0).
SEL_ACTIVE_LOW, 0, 1 = sel outputs are inverted at the pin (selected digit = 0).

Ports:
clk  in  1  system clock
rstz  in  1  asynchronous active-low reset
sys_addr  in  8  byte address within the block; bits [1:0] ignored
sys_wr_data  in  32  write data
sys_en  in  1  access strobe, single cycle
sys_wr_en  in  1  1 = write, 0 = read (qualified by sys_en)
sys_rd_data  out  32  read data, registered
seg  out  7  segments {g,f,e,d,c,b,a}, registered
sel  out  NUM_DIGITS  one-hot digit select, registered

Behaviour:
- Reset is asynchronous on rstz low. On reset: CTRL=0, all DIGIT regs=0, prescaler=0, pwm_cnt=0, digit_idx=0, sys_rd_data=0.
- On reset, seg and sel are inactive. Inactive is all-0, or all-1 when the matching *_ACTIVE_LOW parameter is 1.
- Register map, word offsets:
  - 0x00 CTRL, RW: [0] en; [7:4] bright. Other bits read 0.
  - 0x04 STATUS, RO: [2:0] digit_idx; [7:4] pwm_cnt.
  - 0x08+4*i DIGIT[i], RW, i < NUM_DIGITS: [6:0] segment pattern.
- Writes: take effect on the clk edge where sys_en=1 and sys_wr_en=1. Writes to STATUS or to unmapped offsets are ignored.
- Reads: sys_rd_data updates on the edge where sys_en=1 and sys_wr_en=0, so it is valid the cycle after the strobe. Unmapped offsets return 0. sys_rd_data holds its value when there is no read.
- Scan engine, when en=1:
  - Prescaler counts 0..CLK_DIV-1. On terminal count it wraps and issues one tick.
  - Each tick increments the 4-bit pwm_cnt.
  - When a tick takes pwm_cnt 15->0, digit_idx advances, wrapping NUM_DIGITS-1 -> 0.
  - Digit dwell time is 16*CLK_DIV cycles; full frame is NUM_DIGITS*16*CLK_DIV cycles.
- Output drive, when en=1:
  - sel = onehot(digit_idx), always, regardless of brightness.
  - seg = DIGIT[digit_idx] while pwm_cnt < bright, otherwise 0 (before polarity inversion).
  - bright=0 gives a blank display; bright=15 gives 15/16 duty.
  - seg and sel are registered: a change in state is visible on the pins one cycle later.
  - A write to the currently displayed DIGIT appears on seg 1 cycle after the write edge.
- Disable (en written 0):
  - Next edge: prescaler, pwm_cnt and digit_idx clear to 0.
  - One edge later: seg and sel go inactive.
  - Re-enable starts scanning from digit 0, pwm_cnt 0.
- Changing bright while enabled takes effect immediately; counters are not disturbed.
- A write to CTRL that coincides with a tick: the tick is processed, and the new en/bright apply from the next cycle.
- NUM_DIGITS=1: digit_idx stays 0; the sel bit is constantly asserted while en=1.

Decomposition:
- snowflake_pkg holds:
  - register offset constants SSD_CTRL, SSD_STATUS, SSD_DIGIT0;
  - CTRL field positions;
  - a packed struct for CTRL.
- Sub-module snowflake_ssd_scan contains the prescaler, pwm_cnt and digit_idx counters.
  - Inputs: clk, rstz, en.
  - Outputs: digit_idx, pwm_cnt, tick.
- The top module holds the register file, read mux and output polarity stage.

Test Plan:
1. Reset: rstz low mid-scan with SEG_ACTIVE_LOW=1 -> seg=7'h7F, sel inactive, sys_rd_data=0 immediately, asynchronously. Reads of CTRL and DIGIT[0] return 0 after release.
2. Register R/W with NUM_DIGITS=4:
   - Write DIGIT[3]=0x5B, read at 0x14 -> 0x5B the cycle after the strobe.
   - Read 0x18 -> 0.
   - Write STATUS -> no change.
3. Scan sequence with CLK_DIV=4, NUM_DIGITS=3, CTRL=0xF1:
   - sel runs 001 -> 010 -> 100 -> 001, each held 64 cycles.
   - seg matches the DIGIT of the selected digit.
4. PWM with CLK_DIV=4, bright=4, DIGIT[0]=0x3F:
   - seg=0x3F for 16 cycles, then 0 for 48 cycles, in each dwell.
   - bright=0 -> seg always 0 with sel still scanning.
5. Disable/re-enable:
   - Write en=0 during digit 2 -> sel/seg inactive 2 edges after the write edge, STATUS=0.
   - Re-enable -> sel=onehot(0) 1 cycle after the write edge.
6. Live update: write the displayed digit's register during its on-phase -> seg changes exactly 1 cycle after the write edge, and sel/STATUS are unchanged.
